// File: rtl/pc_update_ctrl.sv
// Multicycle PC-update sequencer: owns every PC write for SEQ/J/JR/branches/reserved-op exceptions.
// Optional statistics counters are built only when PC_CTRL_STATS_EN is defined.
module pc_update_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             abort,
    input  logic             Zero,
    input  logic             Gt,
    input  logic             stats_clr,
    output logic             busy,
    output logic             done,
    output logic             exc,
    output logic             alu_cmp,
    output logic             pc_write,
    output logic [2:0]       pc_source,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_J   = 3'b001;
    localparam logic [2:0] OP_JR  = 3'b010;
    localparam logic [2:0] OP_BEQ = 3'b011;
    localparam logic [2:0] OP_BNE = 3'b100;
    localparam logic [2:0] OP_BGT = 3'b101;
    localparam logic [2:0] OP_BLE = 3'b110;

    localparam logic [2:0] SRC_PC4    = 3'b000;
    localparam logic [2:0] SRC_JUMP   = 3'b001;
    localparam logic [2:0] SRC_REG    = 3'b010;
    localparam logic [2:0] SRC_BRANCH = 3'b011;
    localparam logic [2:0] SRC_EXC    = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INC,
        S_JUMP,
        S_JREG,
        S_CMP,
        S_RESOLVE,
        S_EXC
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] op_reg;
    logic       zero_q, gt_q;
    logic       taken;
    logic       accept;
    logic       wr_raw, done_raw, exc_raw;
    logic [2:0] src_raw;

    assign accept = (state_reg == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_SEQ;
            zero_q    <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg <= op;
            end
            // Flags are valid only while the ALU is doing the compare subtract.
            if (state_reg == S_CMP) begin
                zero_q <= Zero;
                gt_q   <= Gt;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_SEQ:                         state_next = S_INC;
                        OP_J:                           state_next = S_JUMP;
                        OP_JR:                          state_next = S_JREG;
                        OP_BEQ, OP_BNE, OP_BGT, OP_BLE: state_next = S_CMP;
                        default:                        state_next = S_EXC;
                    endcase
                end
            end
            S_CMP:   state_next = S_RESOLVE;
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        case (op_reg)
            OP_BEQ:  taken = zero_q;
            OP_BNE:  taken = ~zero_q;
            OP_BGT:  taken = gt_q;
            OP_BLE:  taken = ~gt_q;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        wr_raw   = 1'b0;
        done_raw = 1'b0;
        exc_raw  = 1'b0;
        src_raw  = SRC_PC4;
        case (state_reg)
            S_INC: begin
                wr_raw   = 1'b1;
                done_raw = 1'b1;
                src_raw  = SRC_PC4;
            end
            S_JUMP: begin
                wr_raw   = 1'b1;
                done_raw = 1'b1;
                src_raw  = SRC_JUMP;
            end
            S_JREG: begin
                wr_raw   = 1'b1;
                done_raw = 1'b1;
                src_raw  = SRC_REG;
            end
            S_RESOLVE: begin
                wr_raw   = taken;
                done_raw = 1'b1;
                src_raw  = SRC_BRANCH;
            end
            S_EXC: begin
                wr_raw   = 1'b1;
                done_raw = 1'b1;
                exc_raw  = 1'b1;
                src_raw  = SRC_EXC;
            end
            default: begin
                wr_raw = 1'b0;
            end
        endcase
    end

    // An abort kills the side effects of the cycle it arrives in; the mux select follows the write.
    assign busy      = (state_reg != S_IDLE);
    assign alu_cmp   = (state_reg == S_CMP);
    assign pc_write  = wr_raw & ~abort;
    assign done      = done_raw & ~abort;
    assign exc       = exc_raw & ~abort;
    assign pc_source = pc_write ? src_raw : SRC_PC4;

`ifdef PC_CTRL_STATS_EN
    logic [CNT_W-1:0] branch_cnt_reg, taken_cnt_reg;
    logic             resolve_fire;

    assign resolve_fire = (state_reg == S_RESOLVE) && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_reg <= '0;
            taken_cnt_reg  <= '0;
        end else if (stats_clr) begin
            branch_cnt_reg <= '0;
            taken_cnt_reg  <= '0;
        end else if (resolve_fire) begin
            if (branch_cnt_reg != {CNT_W{1'b1}}) begin
                branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
            end
            if (taken && (taken_cnt_reg != {CNT_W{1'b1}})) begin
                taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign branch_cnt = branch_cnt_reg;
    assign taken_cnt  = taken_cnt_reg;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign branch_cnt       = '0;
    assign taken_cnt        = '0;
`endif

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Scoreboard bench for pc_update_ctrl: per-cycle stimulus and expected outputs are queued together,
// then each scenario task replays them and compares at the falling edge.
module tb_pc_update_ctrl;

    localparam int CNT_W = 4;
`ifdef PC_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       exc;
        logic       alu_cmp;
        logic       pc_write;
        logic [2:0] pc_source;
    } outs_t;

    typedef struct packed {
        logic       start;
        logic [2:0] op;
        logic       abort;
        logic       zero;
        logic       gt;
        logic       clr;
    } stim_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic             abort;
    logic             zero;
    logic             gt;
    logic             stats_clr;
    logic             busy, done, exc, alu_cmp, pc_write;
    logic [2:0]       pc_source;
    logic [CNT_W-1:0] branch_cnt, taken_cnt;

    int    vectors    = 0;
    int    miscompares = 0;
    stim_t stim[$];
    outs_t sb[$];

    pc_update_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .abort     (abort),
        .Zero      (zero),
        .Gt        (gt),
        .stats_clr (stats_clr),
        .busy      (busy),
        .done      (done),
        .exc       (exc),
        .alu_cmp   (alu_cmp),
        .pc_write  (pc_write),
        .pc_source (pc_source),
        .branch_cnt(branch_cnt),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic branch_taken(input logic [2:0] o, input logic z, input logic g);
        case (o)
            3'd3:    return z;
            3'd4:    return !z;
            3'd5:    return g;
            3'd6:    return !g;
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t sample_outs();
        outs_t o;
        o = {busy, done, exc, alu_cmp, pc_write, pc_source};
        return o;
    endfunction

    // One IDLE-state cycle: whatever is driven, the outputs must all be zero.
    task automatic add_idle(input logic st, input logic [2:0] o, input logic ab, input logic cl);
        stim_t s;
        s       = '0;
        s.start = st;
        s.op    = o;
        s.abort = ab;
        s.clr   = cl;
        stim.push_back(s);
        sb.push_back('0);
    endtask

    // Queue one request: the accepting IDLE cycle plus its busy cycles.
    // abort_at selects the busy cycle (1 or 2) that gets aborted, 0 for none.
    task automatic add_req(input logic [2:0] o, input logic z, input logic g,
                           input int abort_at, input logic hold, input logic clr_res);
        stim_t s;
        outs_t e;
        logic  tk;
        s       = '0;
        s.start = 1'b1;
        s.op    = o;
        stim.push_back(s);
        sb.push_back('0);
        s.start = hold;
        if (o inside {3'd3, 3'd4, 3'd5, 3'd6}) begin
            s.zero  = z;
            s.gt    = g;
            s.abort = (abort_at == 1);
            e         = '0;
            e.busy    = 1'b1;
            e.alu_cmp = 1'b1;
            stim.push_back(s);
            sb.push_back(e);
            if (abort_at != 1) begin
                // Flip the live flags in RESOLVE so only the captured values can decide.
                s.zero  = !z;
                s.gt    = !g;
                s.abort = (abort_at == 2);
                s.clr   = clr_res;
                tk      = branch_taken(o, z, g);
                e       = '0;
                e.busy  = 1'b1;
                if (!s.abort) begin
                    e.done      = 1'b1;
                    e.pc_write  = tk;
                    e.pc_source = tk ? 3'b011 : 3'b000;
                end
                stim.push_back(s);
                sb.push_back(e);
            end
        end else begin
            s.abort = (abort_at == 1);
            e       = '0;
            e.busy  = 1'b1;
            if (!s.abort) begin
                e.done      = 1'b1;
                e.pc_write  = 1'b1;
                e.exc       = (o == 3'd7);
                e.pc_source = (o == 3'd7) ? 3'b100 : o;
            end
            stim.push_back(s);
            sb.push_back(e);
        end
    endtask

    task automatic drive(input stim_t s);
        start     = s.start;
        op        = s.op;
        abort     = s.abort;
        zero      = s.zero;
        gt        = s.gt;
        stats_clr = s.clr;
    endtask

    task automatic test_reset();
        outs_t o, e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            o = sample_outs();
            vectors++;
            if (o !== outs_t'(0) || branch_cnt !== '0 || taken_cnt !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: got outs=%b cnt=%0d/%0d, want outs=00000000 cnt=0/0",
                         o, branch_cnt, taken_cnt);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        o = sample_outs();
        e = '0; e.busy = 1'b1; e.alu_cmp = 1'b1;
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_first_accept: got %b want %b", o, e);
        end
        start = 1'b0;
        @(negedge clk);
        o = sample_outs();
        e = '0; e.busy = 1'b1; e.done = 1'b1; e.pc_write = 1'b1; e.pc_source = 3'b011;
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_first_resolve: got %b want %b", o, e);
        end
        @(posedge clk); #1;
        start = 1'b1;
        op    = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        o = sample_outs();
        e = '0; e.busy = 1'b1; e.done = 1'b1; e.pc_write = 1'b1; e.pc_source = 3'b001;
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_mid_jump: got %b want %b", o, e);
        end
        reset = 1'b0;
        #1;
        o = sample_outs();
        vectors++;
        if (o !== outs_t'(0)) begin
            miscompares++;
            $display("FAIL reset_async_mid: got %b want 00000000", o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        o = sample_outs();
        vectors++;
        if (o !== outs_t'(0)) begin
            miscompares++;
            $display("FAIL reset_after_release: got %b want 00000000", o);
        end
    endtask

    task automatic test_jumps();
        stim_t s;
        outs_t o, e;
        int    cyc = 0;
        add_req(3'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add_req(3'd1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add_req(3'd2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add_req(3'd7, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        add_idle(1'b0, 3'd0, 1'b0, 1'b0);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            drive(s);
            @(negedge clk);
            e = sb.pop_front();
            o = sample_outs();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL jumps cyc %0d op %0d: got %b want %b", cyc, s.op, o, e);
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_branches();
        stim_t s;
        outs_t o, e;
        int    cyc = 0;
        for (int b = 3; b <= 6; b++) begin
            for (int c = 0; c < 4; c++) begin
                add_req(3'(b), c[0], c[1], 0, 1'b0, 1'b0);
            end
        end
        add_idle(1'b0, 3'd0, 1'b0, 1'b0);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            drive(s);
            @(negedge clk);
            e = sb.pop_front();
            o = sample_outs();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL branches cyc %0d op %0d z %0d g %0d: got %b want %b",
                         cyc, s.op, s.zero, s.gt, o, e);
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_abort_hold();
        stim_t s;
        outs_t o, e;
        int    cyc = 0;
        add_req(3'd3, 1'b1, 1'b0, 1, 1'b0, 1'b0);
        add_idle(1'b0, 3'd0, 1'b0, 1'b0);
        add_req(3'd4, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        add_idle(1'b0, 3'd0, 1'b0, 1'b0);
        add_req(3'd1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        add_idle(1'b0, 3'd0, 1'b0, 1'b0);
        add_req(3'd7, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        add_idle(1'b0, 3'd0, 1'b0, 1'b0);
        add_idle(1'b1, 3'd1, 1'b1, 1'b0);
        add_idle(1'b0, 3'd1, 1'b0, 1'b0);
        add_req(3'd5, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        add_idle(1'b0, 3'd0, 1'b0, 1'b0);
        add_req(3'd0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        add_idle(1'b0, 3'd0, 1'b0, 1'b0);
        while (stim.size() > 0) begin
            s = stim.pop_front();
            drive(s);
            @(negedge clk);
            e = sb.pop_front();
            o = sample_outs();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL abort_hold cyc %0d op %0d abort %0d: got %b want %b",
                         cyc, s.op, s.abort, o, e);
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_stats();
        stim_t            s;
        outs_t            o, e;
        int               cyc = 0;
        logic [CNT_W-1:0] want_b, want_t;
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 0) begin
                add_idle(1'b0, 3'd0, 1'b0, 1'b1);
                for (int i = 0; i < 3; i++) add_req(3'd3, 1'b1, 1'b0, 0, 1'b0, 1'b0);
                for (int i = 0; i < 2; i++) add_req(3'd4, 1'b1, 1'b0, 0, 1'b0, 1'b0);
                add_req(3'd3, 1'b1, 1'b0, 2, 1'b0, 1'b0);
                want_b = STATS ? CNT_W'(5) : '0;
                want_t = STATS ? CNT_W'(3) : '0;
            end else if (phase == 1) begin
                for (int i = 0; i < 20; i++) add_req(3'd3, 1'b1, 1'b0, 0, 1'b0, 1'b0);
                want_b = STATS ? CNT_W'(15) : '0;
                want_t = STATS ? CNT_W'(15) : '0;
            end else begin
                add_req(3'd3, 1'b1, 1'b0, 0, 1'b0, 1'b1);
                want_b = '0;
                want_t = '0;
            end
            add_idle(1'b0, 3'd0, 1'b0, 1'b0);
            while (stim.size() > 0) begin
                s = stim.pop_front();
                drive(s);
                @(negedge clk);
                e = sb.pop_front();
                o = sample_outs();
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL stats_seq phase %0d cyc %0d: got %b want %b", phase, cyc, o, e);
                end
                @(posedge clk); #1;
                cyc++;
            end
            vectors++;
            if (branch_cnt !== want_b || taken_cnt !== want_t) begin
                miscompares++;
                $display("FAIL stats_cnt phase %0d: got branch=%0d taken=%0d want branch=%0d taken=%0d",
                         phase, branch_cnt, taken_cnt, want_b, want_t);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b1;
        op        = 3'd3;
        abort     = 1'b0;
        zero      = 1'b1;
        gt        = 1'b0;
        stats_clr = 1'b0;
        test_reset();
        test_jumps();
        test_branches();
        test_abort_hold();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
